arith_mult_arbiter: RTL and testbench

ARITH_MULT_ARBITER -- requirements
Module: arith_mult_arbiter

---
 rtl/arith_mult_arbiter_pkg.sv | 16 +
 rtl/arith_mult_core_pkg.sv | 13 +
 rtl/arith_mult_arbiter_res_fifo.sv | 58 +++++
 rtl/arith_mult_core_with_side.sv | 66 ++++++
 rtl/arith_mult_arbiter.sv | 163 ++++++++++++++++
 tb/tb_arith_mult_arbiter.sv | 240 ++++++++++++++++++++++++
 6 files changed

// File: rtl/arith_mult_arbiter_pkg.sv
// rtl/arith_mult_arbiter_pkg.sv - shared width helpers for the multiplier arbiter
// Purpose: requester-id width and credit-counter width used by the arbiter top.
// Ports: none (package).
package arith_mult_arbiter_pkg;

  // Width of the requester id carried as multiplier side data.
  function automatic int id_width(input int nb_req);
    return (nb_req > 1) ? $clog2(nb_req) : 1;
  endfunction

  // Credit counters must hold 0..res_depth inclusive.
  function automatic int credit_width(input int res_depth);
    return $clog2(res_depth + 1);
  endfunction

endpackage

// File: rtl/arith_mult_core_pkg.sv
// rtl/arith_mult_core_pkg.sv - latency definition for the shared multiplier core
// Purpose: single source of truth for the multiplier core's internal pipeline depth.
// Ports: none (package).
package arith_mult_core_pkg;

  localparam int CORE_BASE_LAT = 2;

  // Cycles from in_avail to out_avail, excluding any extra input pipelining.
  function automatic int get_latency();
    return CORE_BASE_LAT;
  endfunction

endpackage

// File: rtl/arith_mult_arbiter_res_fifo.sv
// rtl/arith_mult_arbiter_res_fifo.sv - per-requester result FIFO
// Purpose: holds finished products for one requester in completion order.
// Ports:
//   clk, a_rst_n        - clock, asynchronous active-low reset
//   push/push_data      - write strobe and product (never asserted when full)
//   pop                 - consume the head entry
//   out_vld/out_data    - head valid and head product (zero when empty)
module arith_mult_arbiter_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         a_rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  // Overflow is prevented upstream by the credit scheme, so push is unguarded.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Gating keeps the head at zero while empty, including straight after reset.
  assign out_vld  = (cnt_q != '0);
  assign out_data = out_vld ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/arith_mult_core_with_side.sv
// rtl/arith_mult_core_with_side.sv - pipelined unsigned multiplier with side-data lane
// Purpose: full-width unsigned A*B with a fixed latency; side data travels alongside.
// Ports:
//   clk, a_rst_n        - clock, asynchronous active-low reset
//   in_avail/in_a/in_b  - operand strobe and operands
//   in_side             - tag carried with the operation
//   out_avail/out_z     - result strobe and product, get_latency()+IN_PIPE cycles later
//   out_side            - tag matching out_z
module arith_mult_core_with_side
  import arith_mult_core_pkg::*;
#(
  parameter int A_W     = 16,
  parameter int B_W     = 16,
  parameter int IN_PIPE = 0,
  parameter int SIDE_W  = 1
) (
  input  logic              clk,
  input  logic              a_rst_n,
  input  logic              in_avail,
  input  logic [A_W-1:0]    in_a,
  input  logic [B_W-1:0]    in_b,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_avail,
  output logic [A_W+B_W-1:0] out_z,
  output logic [SIDE_W-1:0] out_side
);

  localparam int LAT = get_latency() + IN_PIPE;
  localparam int Z_W = A_W + B_W;

  logic [LAT-1:0]             vld_q, vld_d;
  logic [LAT-1:0][Z_W-1:0]    z_q, z_d;
  logic [LAT-1:0][SIDE_W-1:0] side_q, side_d;

  // The product is formed into stage 0; later stages only delay it.
  always_comb begin
    vld_d     = vld_q;
    z_d       = z_q;
    side_d    = side_q;
    vld_d[0]  = in_avail;
    z_d[0]    = Z_W'(in_a) * Z_W'(in_b);
    side_d[0] = in_side;
    for (int k = 1; k < LAT; k++) begin
      vld_d[k]  = vld_q[k-1];
      z_d[k]    = z_q[k-1];
      side_d[k] = side_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      vld_q  <= '0;
      z_q    <= '0;
      side_q <= '0;
    end else begin
      vld_q  <= vld_d;
      z_q    <= z_d;
      side_q <= side_d;
    end
  end

  assign out_avail = vld_q[LAT-1];
  assign out_z     = z_q[LAT-1];
  assign out_side  = side_q[LAT-1];

endmodule

// File: rtl/arith_mult_arbiter.sv
// rtl/arith_mult_arbiter.sv - round-robin sharing of one multiplier among requesters
// Purpose: grants one credited requester per cycle, issues to a shared multiplier
//          and returns each product to the issuing requester's result FIFO.
// Ports:
//   clk, a_rst_n     - clock, asynchronous active-low reset
//   req_vld/req_rdy  - per-requester operand handshake (req_rdy one-hot or zero)
//   req_a/req_b      - packed operands, requester i at slice i
//   res_vld/res_rdy  - per-requester result handshake
//   res_z            - packed products, requester i at slice i
//   busy             - any operation issued, in flight or buffered
module arith_mult_arbiter
  import arith_mult_arbiter_pkg::*;
#(
  parameter int NB_REQ    = 4,
  parameter int OP_A_W    = 16,
  parameter int OP_B_W    = 16,
  parameter int IN_PIPE   = 0,
  parameter int RES_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                a_rst_n,
  input  logic [NB_REQ-1:0]                   req_vld,
  output logic [NB_REQ-1:0]                   req_rdy,
  input  logic [NB_REQ*OP_A_W-1:0]            req_a,
  input  logic [NB_REQ*OP_B_W-1:0]            req_b,
  output logic [NB_REQ-1:0]                   res_vld,
  input  logic [NB_REQ-1:0]                   res_rdy,
  output logic [NB_REQ*(OP_A_W+OP_B_W)-1:0]   res_z,
  output logic                                busy
);

  localparam int ID_W   = id_width(NB_REQ);
  localparam int CRED_W = credit_width(RES_DEPTH);
  localparam int Z_W    = OP_A_W + OP_B_W;
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(RES_DEPTH);

  logic [NB_REQ-1:0][CRED_W-1:0] credit_q, credit_d;
  logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic                          iss_vld_q, iss_vld_d;
  logic [OP_A_W-1:0]             iss_a_q, iss_a_d;
  logic [OP_B_W-1:0]             iss_b_q, iss_b_d;
  logic [ID_W-1:0]               iss_id_q, iss_id_d;

  logic [NB_REQ-1:0]             eligible;
  logic [NB_REQ-1:0]             grant;
  logic [NB_REQ-1:0]             pop;
  logic                          core_vld;
  logic [Z_W-1:0]                core_z;
  logic [ID_W-1:0]               core_id;
  logic [NB_REQ-1:0][Z_W-1:0]    fifo_z;

  // Credit counts free result slots net of in-flight work; a zero credit removes
  // the requester from arbitration. Gating with a_rst_n keeps req_rdy low while
  // reset is asserted, yet allows a grant in the first cycle after release.
  always_comb begin
    for (int i = 0; i < NB_REQ; i++) begin
      eligible[i] = a_rst_n && req_vld[i] && (credit_q[i] != '0);
    end
  end

  always_comb begin : arb
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    grant     = '0;
    rr_ptr_d  = rr_ptr_q;
    iss_vld_d = 1'b0;
    iss_a_d   = iss_a_q;
    iss_b_d   = iss_b_q;
    iss_id_d  = iss_id_q;
    for (int k = 0; k < NB_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NB_REQ;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        iss_vld_d  = 1'b1;
        iss_a_d    = req_a[idx*OP_A_W +: OP_A_W];
        iss_b_d    = req_b[idx*OP_B_W +: OP_B_W];
        iss_id_d   = ID_W'(idx);
        rr_ptr_d   = ID_W'((idx + 1) % NB_REQ);
      end
    end
  end

  assign req_rdy = grant;
  assign pop     = res_vld & res_rdy;

  always_comb begin
    for (int i = 0; i < NB_REQ; i++) begin
      credit_d[i] = credit_q[i];
      case ({grant[i], pop[i]})
        2'b10:   credit_d[i] = credit_q[i] - 1'b1;
        2'b01:   credit_d[i] = credit_q[i] + 1'b1;
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  // In-flight work is already reflected in the credits, so only the issue
  // register needs to be looked at separately.
  always_comb begin
    busy = iss_vld_q;
    for (int i = 0; i < NB_REQ; i++) begin
      if (credit_q[i] != CRED_FULL) busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int i = 0; i < NB_REQ; i++) credit_q[i] <= CRED_FULL;
      rr_ptr_q  <= '0;
      iss_vld_q <= 1'b0;
      iss_a_q   <= '0;
      iss_b_q   <= '0;
      iss_id_q  <= '0;
    end else begin
      credit_q  <= credit_d;
      rr_ptr_q  <= rr_ptr_d;
      iss_vld_q <= iss_vld_d;
      iss_a_q   <= iss_a_d;
      iss_b_q   <= iss_b_d;
      iss_id_q  <= iss_id_d;
    end
  end

  arith_mult_core_with_side #(
    .A_W     (OP_A_W),
    .B_W     (OP_B_W),
    .IN_PIPE (IN_PIPE),
    .SIDE_W  (ID_W)
  ) u_core (
    .clk       (clk),
    .a_rst_n   (a_rst_n),
    .in_avail  (iss_vld_q),
    .in_a      (iss_a_q),
    .in_b      (iss_b_q),
    .in_side   (iss_id_q),
    .out_avail (core_vld),
    .out_z     (core_z),
    .out_side  (core_id)
  );

  for (genvar i = 0; i < NB_REQ; i++) begin : g_res
    localparam logic [ID_W-1:0] MY_ID = ID_W'(i);

    arith_mult_arbiter_res_fifo #(
      .DEPTH (RES_DEPTH),
      .W     (Z_W)
    ) u_fifo (
      .clk       (clk),
      .a_rst_n   (a_rst_n),
      .push      (core_vld && (core_id == MY_ID)),
      .push_data (core_z),
      .pop       (pop[i]),
      .out_vld   (res_vld[i]),
      .out_data  (fifo_z[i])
    );

    assign res_z[i*Z_W +: Z_W] = fifo_z[i];
  end

endmodule

// File: tb/tb_arith_mult_arbiter.sv
// tb/tb_arith_mult_arbiter.sv - self-checking bench for arith_mult_arbiter
module tb_arith_mult_arbiter;
  import arith_mult_core_pkg::*;

  localparam int NB    = 4;
  localparam int AW    = 16;
  localparam int BW    = 16;
  localparam int ZW    = AW + BW;
  localparam int DEPTH = 4;
  localparam int LAT   = get_latency();

  logic              clk = 1'b0;
  logic              a_rst_n = 1'b0;
  logic [NB-1:0]     req_vld = '0;
  logic [NB-1:0]     req_rdy;
  logic [NB*AW-1:0]  req_a = '0;
  logic [NB*BW-1:0]  req_b = '0;
  logic [NB-1:0]     res_vld;
  logic [NB-1:0]     res_rdy = '0;
  logic [NB*ZW-1:0]  res_z;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_cnt1 = 0;

  // Reference model: credits, round-robin pointer, visible results per
  // requester and a time-ordered list of products still in the multiplier.
  int          credit [NB];
  int          ptr;
  bit          iss_pend;
  logic [ZW-1:0] q [NB][$];
  int          pend_due [$];
  int          pend_id [$];
  logic [ZW-1:0] pend_z [$];

  always #5 clk = ~clk;

  arith_mult_arbiter #(
    .NB_REQ    (NB),
    .OP_A_W    (AW),
    .OP_B_W    (BW),
    .IN_PIPE   (0),
    .RES_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req_a   (req_a),
    .req_b   (req_b),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .res_z   (res_z),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      credit[i] = DEPTH;
      q[i].delete();
    end
    pend_due.delete();
    pend_id.delete();
    pend_z.delete();
    ptr = 0;
    iss_pend = 1'b0;
  endtask

  task automatic rand_operands();
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, advance the model.
  task automatic step();
    int g;
    logic [NB-1:0] exp_rdy;
    bit exp_busy;
    @(negedge clk);
    while (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      q[pend_id[0]].push_back(pend_z[0]);
      void'(pend_due.pop_front());
      void'(pend_id.pop_front());
      void'(pend_z.pop_front());
    end
    g = -1;
    for (int k = 0; k < NB; k++) begin
      if (g < 0 && req_vld[(ptr + k) % NB] && credit[(ptr + k) % NB] > 0) g = (ptr + k) % NB;
    end
    exp_rdy = (g >= 0) ? NB'(1 << g) : '0;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    if (req_rdy[1]) rdy_cnt1++;
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("res_vld[%0d]", i), 64'(res_vld[i]), 64'(q[i].size() > 0));
      if (q[i].size() > 0) chk($sformatf("res_z[%0d]", i), 64'(res_z[i*ZW +: ZW]), 64'(q[i][0]));
    end
    exp_busy = iss_pend;
    for (int i = 0; i < NB; i++) if (credit[i] != DEPTH) exp_busy = 1'b1;
    chk("busy", 64'(busy), 64'(exp_busy));
    iss_pend = (g >= 0);
    if (g >= 0) begin
      credit[g]--;
      pend_due.push_back(cyc + 2 + LAT);
      pend_id.push_back(g);
      pend_z.push_back(ZW'(req_a[g*AW +: AW]) * ZW'(req_b[g*BW +: BW]));
      ptr = (g + 1) % NB;
    end
    for (int i = 0; i < NB; i++) begin
      if (q[i].size() > 0 && res_rdy[i]) begin
        void'(q[i].pop_front());
        credit[i]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int t0;
    // Reset state, with requests already pending to show req_rdy is held off.
    model_reset();
    req_vld = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'h0);
    chk("rst_res_vld", 64'(res_vld), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_res_z", 64'(res_z), 64'h0);
    req_vld = '0;
    a_rst_n = 1'b1;

    // Single requester: 3*5 on requester 2 appears at t+2+LAT only.
    t0 = cyc;
    req_vld = 4'b0100;
    req_a[2*AW +: AW] = 16'd3;
    req_b[2*BW +: BW] = 16'd5;
    step();
    req_vld = '0;
    repeat (1 + LAT) step();
    chk("single_cycle", 64'(cyc), 64'(t0 + 2 + LAT));
    chk("single_res_vld", 64'(res_vld), 64'b0100);
    chk("single_res_z", 64'(res_z[2*ZW +: ZW]), 64'd15);
    res_rdy = '1;
    repeat (3) step();

    // All requesters active, results drained every cycle.
    req_vld = '1;
    repeat (16) begin
      rand_operands();
      step();
    end
    req_vld = '0;
    repeat (LAT + 4) step();

    // Requester 1 never drains: four grants, then skipped; one pop gives one more.
    rdy_cnt1 = 0;
    req_vld = '1;
    res_rdy = 4'b1101;
    repeat (20) begin
      rand_operands();
      step();
    end
    chk("req1_grants_at_zero_credit", 64'(rdy_cnt1), 64'd4);
    res_rdy = '1;
    step();
    res_rdy = 4'b1101;
    repeat (10) begin
      rand_operands();
      step();
    end
    chk("req1_grants_after_pop", 64'(rdy_cnt1), 64'd5);
    req_vld = '0;
    res_rdy = '1;
    repeat (LAT + 8) step();

    // Largest operands.
    req_vld = 4'b0001;
    req_a[AW-1:0] = 16'hFFFF;
    req_b[BW-1:0] = 16'hFFFF;
    step();
    req_vld = '0;
    res_rdy = '0;
    repeat (1 + LAT) step();
    chk("max_res_z", 64'(res_z[ZW-1:0]), 64'hFFFE0001);
    res_rdy = '1;
    repeat (2) step();

    // Reset with three operations in flight.
    req_vld = '1;
    repeat (3) begin
      rand_operands();
      step();
    end
    a_rst_n = 1'b0;
    #2;
    chk("midrst_req_rdy", 64'(req_rdy), 64'h0);
    chk("midrst_res_vld", 64'(res_vld), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_res_z", 64'(res_z), 64'h0);
    req_vld = '0;
    a_rst_n = 1'b1;
    model_reset();
    repeat (LAT + 4) step();
    req_vld = '1;
    #1;
    chk("rr_ptr_after_reset", 64'(req_rdy), 64'b0001);
    step();
    req_vld = '0;
    repeat (LAT + 4) step();

    // Random soak.
    repeat (2000) begin
      req_vld = NB'($urandom);
      res_rdy = NB'($urandom) | NB'($urandom);
      rand_operands();
      step();
    end
    req_vld = '0;
    res_rdy = '1;
    repeat (LAT + 8) step();
    chk("final_idle_busy", 64'(busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
